// File: rtl/datapath_pkg.sv
// Shared constants for the teaching-CPU datapath: widths, ALU op codes, IR field positions.
package datapath_pkg;

    localparam int WIDTH        = 32;
    localparam int NREGS        = 16;
    localparam int REG_SEL_BITS = 4;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_AND  = 5'd2;
    localparam logic [4:0] OP_OR   = 5'd3;
    localparam logic [4:0] OP_SHR  = 5'd4;
    localparam logic [4:0] OP_SHRA = 5'd5;
    localparam logic [4:0] OP_SHL  = 5'd6;
    localparam logic [4:0] OP_ROR  = 5'd7;
    localparam logic [4:0] OP_ROL  = 5'd8;
    localparam logic [4:0] OP_MUL  = 5'd9;
    localparam logic [4:0] OP_DIV  = 5'd10;
    localparam logic [4:0] OP_NEG  = 5'd11;
    localparam logic [4:0] OP_NOT  = 5'd12;

    localparam int IR_RA_LSB = 23;
    localparam int IR_RB_LSB = 19;
    localparam int IR_RC_LSB = 15;
    localparam int IR_C_BITS = 19;

endpackage

// File: rtl/data_path_alu.sv
// Datapath ALU: A (Y register) op B (bus) -> 64-bit Z value.
// Signed divider present only when DATAPATH_DIV_EN is defined.
module alu
    import datapath_pkg::*;
(
    input  logic [4:0]         ops,
    input  logic               inc_pc,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] result
);

    logic [4:0]                sh;
    logic signed [2*WIDTH-1:0] sa;
    logic signed [2*WIDTH-1:0] sb;
    logic [2*WIDTH-1:0]        mul_res;
    logic [2*WIDTH-1:0]        div_res;

    assign sh      = b[4:0];
    assign sa      = {{WIDTH{a[WIDTH-1]}}, a};
    assign sb      = {{WIDTH{b[WIDTH-1]}}, b};
    assign mul_res = sa * sb;

`ifdef DATAPATH_DIV_EN
    logic signed [WIDTH-1:0] quo;
    logic signed [WIDTH-1:0] rem;

    always_comb begin
        quo = '0;
        rem = '0;
        if (b != '0) begin
            quo = $signed(a) / $signed(b);
            rem = $signed(a) % $signed(b);
        end
    end

    assign div_res = {rem, quo};
`else
    assign div_res = '0;
`endif

    // Rotates: a shift by 32 yields 0, so a zero rotate falls out naturally.
    always_comb begin
        result = '0;
        if (inc_pc) begin
            result[WIDTH-1:0] = b + WIDTH'(1);
        end else begin
            case (ops)
                OP_ADD:  result[WIDTH-1:0] = a + b;
                OP_SUB:  result[WIDTH-1:0] = a - b;
                OP_AND:  result[WIDTH-1:0] = a & b;
                OP_OR:   result[WIDTH-1:0] = a | b;
                OP_SHR:  result[WIDTH-1:0] = a >> sh;
                OP_SHRA: result[WIDTH-1:0] = WIDTH'($signed(a) >>> sh);
                OP_SHL:  result[WIDTH-1:0] = a << sh;
                OP_ROR:  result[WIDTH-1:0] = (a >> sh) | (a << (6'd32 - 6'(sh)));
                OP_ROL:  result[WIDTH-1:0] = (a << sh) | (a >> (6'd32 - 6'(sh)));
                OP_MUL:  result = mul_res;
                OP_DIV:  result = div_res;
                OP_NEG:  result[WIDTH-1:0] = '0 - b;
                OP_NOT:  result[WIDTH-1:0] = ~b;
                default: result = '0;
            endcase
        end
    end

endmodule

// File: rtl/data_path.sv
// Single-bus 32-bit datapath: register file, special registers, bus mux, IR select/encode, ALU.
// Optional signed divider enabled with DATAPATH_DIV_EN.
module data_path
    import datapath_pkg::*;
(
    input  logic             clock,
    input  logic             clear,
    input  logic [WIDTH-1:0] Mdatain,
    input  logic [WIDTH-1:0] in_port,
    input  logic [4:0]       ops,
    input  logic             R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
    input  logic             R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
    input  logic             RAout, RYout, RZHIout, RZLOout, PCout, IRout, HIout, LOout,
    input  logic             MDRout, MARout, InPortOut, PORTout, Cout,
    input  logic             R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in,
    input  logic             R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in,
    input  logic             RAin, RYin, RZin, PCin, IRin, HIin, LOin, MDRin, MARin, PORTin,
    input  logic             Read, Write,
    input  logic             gra, grb, grc, rin, rout, BAout, IncPC,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             mem_write,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] bus_dbg
);

    logic [WIDTH-1:0]        regs [NREGS];
    logic [WIDTH-1:0]        ra, y, pc, ir, hi, lo, mdr, mar, port_q;
    logic [2*WIDTH-1:0]      z, alu_res;
    logic [NREGS-1:0]        r_out, r_in, r_ld;
    logic [REG_SEL_BITS-1:0] sel;
    logic [WIDTH-1:0]        bus, c_val, sel_val;
    logic                    r_hit;
    logic                    unused_opcode;

    assign r_out = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                    R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};
    assign r_in  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                    R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};

    assign sel     = ({REG_SEL_BITS{gra}} & ir[IR_RA_LSB +: REG_SEL_BITS])
                   | ({REG_SEL_BITS{grb}} & ir[IR_RB_LSB +: REG_SEL_BITS])
                   | ({REG_SEL_BITS{grc}} & ir[IR_RC_LSB +: REG_SEL_BITS]);
    assign sel_val = (BAout && sel == '0) ? '0 : regs[sel];
    assign c_val   = {{(WIDTH-IR_C_BITS){ir[IR_C_BITS-1]}}, ir[IR_C_BITS-1:0]};
    assign r_ld    = r_in | ({NREGS{rin}} & (NREGS'(1) << sel));
    assign unused_opcode = ^ir[WIDTH-1:IR_RA_LSB+REG_SEL_BITS];

    // Sources applied lowest priority first so later matches override;
    // the register-file scan keeps only the lowest-numbered asserted Rn.
    always_comb begin
        bus   = '0;
        r_hit = 1'b0;
        if (rout || BAout) bus = sel_val;
        if (Cout)          bus = c_val;
        if (PORTout)       bus = port_q;
        if (InPortOut)     bus = in_port;
        if (MARout)        bus = mar;
        if (MDRout)        bus = mdr;
        if (LOout)         bus = lo;
        if (HIout)         bus = hi;
        if (IRout)         bus = ir;
        if (PCout)         bus = pc;
        if (RZLOout)       bus = z[WIDTH-1:0];
        if (RZHIout)       bus = z[2*WIDTH-1:WIDTH];
        if (RYout)         bus = y;
        if (RAout)         bus = ra;
        for (int unsigned i = 0; i < NREGS; i++) begin
            if (r_out[i] && !r_hit) begin
                bus   = regs[i];
                r_hit = 1'b1;
            end
        end
    end

    alu u_alu (
        .ops    (ops),
        .inc_pc (IncPC),
        .a      (y),
        .b      (bus),
        .result (alu_res)
    );

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
            ra     <= '0;
            y      <= '0;
            z      <= '0;
            pc     <= '0;
            ir     <= '0;
            hi     <= '0;
            lo     <= '0;
            mdr    <= '0;
            mar    <= '0;
            port_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                if (r_ld[i]) regs[i] <= bus;
            end
            if (RAin)   ra     <= bus;
            if (RYin)   y      <= bus;
            if (RZin)   z      <= alu_res;
            if (PCin)   pc     <= bus;
            if (IRin)   ir     <= bus;
            if (HIin)   hi     <= bus;
            if (LOin)   lo     <= bus;
            if (MDRin)  mdr    <= Read ? Mdatain : bus;
            if (MARin)  mar    <= bus;
            if (PORTin) port_q <= bus;
        end
    end

    assign mem_addr  = mar;
    assign mem_wdata = mdr;
    assign out_port  = port_q;
    assign mem_write = Write & clear;
    assign bus_dbg   = clear ? bus : '0;

endmodule

// File: tb/tb_data_path.sv
// Self-checking bench for data_path: directed sequences, ALU vector table, randomized model checks.
module tb_data_path;
    import datapath_pkg::*;

`ifdef DATAPATH_DIV_EN
    localparam bit DIV_ON = 1'b1;
`else
    localparam bit DIV_ON = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        clear;
    logic [31:0] mdatain, in_port;
    logic [4:0]  ops_s;
    logic [15:0] r_out, r_in;
    logic ra_out, ry_out, rzhi_out, rzlo_out, pc_out, ir_out, hi_out, lo_out;
    logic mdr_out, mar_out, inport_out, port_out, c_out;
    logic ra_in, ry_in, rz_in, pc_in, ir_in, hi_in, lo_in, mdr_in, mar_in, port_in;
    logic rd, wr, gra, grb, grc, rin, rout, ba_out, inc_pc;
    logic [31:0] mem_addr, mem_wdata, out_port, bus_dbg;
    logic        mem_write;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    data_path dut (
        .clock(clock), .clear(clear), .Mdatain(mdatain), .in_port(in_port), .ops(ops_s),
        .R0out(r_out[0]), .R1out(r_out[1]), .R2out(r_out[2]), .R3out(r_out[3]),
        .R4out(r_out[4]), .R5out(r_out[5]), .R6out(r_out[6]), .R7out(r_out[7]),
        .R8out(r_out[8]), .R9out(r_out[9]), .R10out(r_out[10]), .R11out(r_out[11]),
        .R12out(r_out[12]), .R13out(r_out[13]), .R14out(r_out[14]), .R15out(r_out[15]),
        .RAout(ra_out), .RYout(ry_out), .RZHIout(rzhi_out), .RZLOout(rzlo_out),
        .PCout(pc_out), .IRout(ir_out), .HIout(hi_out), .LOout(lo_out),
        .MDRout(mdr_out), .MARout(mar_out), .InPortOut(inport_out), .PORTout(port_out), .Cout(c_out),
        .R0in(r_in[0]), .R1in(r_in[1]), .R2in(r_in[2]), .R3in(r_in[3]),
        .R4in(r_in[4]), .R5in(r_in[5]), .R6in(r_in[6]), .R7in(r_in[7]),
        .R8in(r_in[8]), .R9in(r_in[9]), .R10in(r_in[10]), .R11in(r_in[11]),
        .R12in(r_in[12]), .R13in(r_in[13]), .R14in(r_in[14]), .R15in(r_in[15]),
        .RAin(ra_in), .RYin(ry_in), .RZin(rz_in), .PCin(pc_in), .IRin(ir_in),
        .HIin(hi_in), .LOin(lo_in), .MDRin(mdr_in), .MARin(mar_in), .PORTin(port_in),
        .Read(rd), .Write(wr), .gra(gra), .grb(grb), .grc(grc), .rin(rin), .rout(rout),
        .BAout(ba_out), .IncPC(inc_pc),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
        .out_port(out_port), .bus_dbg(bus_dbg)
    );

    task automatic idle();
        r_out = '0; r_in = '0; ops_s = '0;
        ra_out = 0; ry_out = 0; rzhi_out = 0; rzlo_out = 0; pc_out = 0; ir_out = 0;
        hi_out = 0; lo_out = 0; mdr_out = 0; mar_out = 0; inport_out = 0; port_out = 0; c_out = 0;
        ra_in = 0; ry_in = 0; rz_in = 0; pc_in = 0; ir_in = 0; hi_in = 0; lo_in = 0;
        mdr_in = 0; mar_in = 0; port_in = 0;
        rd = 0; wr = 0; gra = 0; grb = 0; grc = 0; rin = 0; rout = 0; ba_out = 0; inc_pc = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Strobes for the read are set by the caller; sample bus mid-cycle, then idle one cycle.
    task automatic sample_bus(output logic [31:0] v);
        #1;
        v = bus_dbg;
        idle();
        tick();
    endtask

    task automatic put_reg(input int unsigned k, input logic [31:0] v);
        idle(); in_port = v; inport_out = 1; r_in[k] = 1; tick(); idle();
    endtask

    task automatic get_reg(input int unsigned k, output logic [31:0] v);
        idle(); r_out[k] = 1; sample_bus(v);
    endtask

    task automatic set_ir(input logic [31:0] v);
        idle(); in_port = v; inport_out = 1; ir_in = 1; tick(); idle();
    endtask

    task automatic run_alu(input logic [4:0] op, input bit inc, input logic [31:0] a,
                           input logic [31:0] b, output logic [63:0] z);
        idle(); in_port = a; inport_out = 1; ry_in = 1; tick();
        idle(); in_port = b; inport_out = 1; ops_s = op; inc_pc = inc; rz_in = 1; tick();
        idle(); rzhi_out = 1; #1; z[63:32] = bus_dbg;
        rzhi_out = 0; rzlo_out = 1; #1; z[31:0] = bus_dbg;
        idle(); tick();
    endtask

    function automatic logic [63:0] model(input logic [4:0] op, input bit inc,
                                          input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb;
        int unsigned n;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        n  = b % 32;
        r  = '0;
        if (inc) begin
            r = b + 32'd1;
            return {32'h0, r};
        end
        case (op)
            OP_ADD:  r = 32'(longint'(a) + longint'(b));
            OP_SUB:  r = 32'(longint'(a) - longint'(b));
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_SHR:  r = 32'(longint'(a) / (longint'(1) << n));
            OP_SHRA: r = 32'(sa >>> n);
            OP_SHL:  r = 32'(longint'(a) * (longint'(1) << n));
            OP_ROR: begin
                r = a;
                for (int unsigned i = 0; i < n; i++) r = {r[0], r[31:1]};
            end
            OP_ROL: begin
                r = a;
                for (int unsigned i = 0; i < n; i++) r = {r[30:0], r[31]};
            end
            OP_MUL:  return 64'(sa * sb);
            OP_DIV:  return (DIV_ON && b != 0) ? {32'(sa % sb), 32'(sa / sb)} : 64'h0;
            OP_NEG:  r = 32'(0 - longint'(b));
            OP_NOT:  r = ~b;
            default: r = '0;
        endcase
        return {32'h0, r};
    endfunction

    typedef struct {
        logic [4:0]  op;
        bit          inc;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[17];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        logic [63:0] z;
        logic [31:0] rf [16];

        vecs[0]  = '{OP_ADD,  1'b0, 32'hFFFFFFFF, 32'h00000002, 64'h0000000000000001};
        vecs[1]  = '{OP_SUB,  1'b0, 32'h00000005, 32'h00000007, 64'h00000000FFFFFFFE};
        vecs[2]  = '{OP_AND,  1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 64'h0000000000F000F0};
        vecs[3]  = '{OP_OR,   1'b0, 32'hF0F0F0F0, 32'h0F0F0000, 64'h00000000FFFFF0F0};
        vecs[4]  = '{OP_SHR,  1'b0, 32'h80000000, 32'h00000024, 64'h0000000008000000};
        vecs[5]  = '{OP_SHRA, 1'b0, 32'h80000000, 32'h00000004, 64'h00000000F8000000};
        vecs[6]  = '{OP_SHL,  1'b0, 32'h00000001, 32'h0000001F, 64'h0000000080000000};
        vecs[7]  = '{OP_ROR,  1'b0, 32'h12345678, 32'h00000004, 64'h0000000081234567};
        vecs[8]  = '{OP_ROL,  1'b0, 32'h12345678, 32'h00000008, 64'h0000000034567812};
        vecs[9]  = '{OP_ROR,  1'b0, 32'h12345678, 32'h00000020, 64'h0000000012345678};
        vecs[10] = '{OP_MUL,  1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF00000001};
        vecs[11] = '{OP_DIV,  1'b0, 32'hFFFFFFEF, 32'h00000005,
                     DIV_ON ? 64'hFFFFFFFEFFFFFFFD : 64'h0};
        vecs[12] = '{OP_DIV,  1'b0, 32'h00000005, 32'h00000000, 64'h0};
        vecs[13] = '{OP_NEG,  1'b0, 32'h00000000, 32'h00000001, 64'h00000000FFFFFFFF};
        vecs[14] = '{OP_NOT,  1'b0, 32'h00000000, 32'h0F0F0F0F, 64'h00000000F0F0F0F0};
        vecs[15] = '{5'd13,   1'b0, 32'h12345678, 32'h11111111, 64'h0};
        vecs[16] = '{OP_SUB,  1'b1, 32'h00000009, 32'hFFFFFFFF, 64'h0};

        // Reset: outputs held at 0 even with a driver and Write asserted.
        idle();
        clear = 1'b0; mdatain = '0; in_port = 32'h0000FFFF;
        inport_out = 1; wr = 1;
        #3;
        check("reset_bus", bus_dbg, 0);
        check("reset_mem_write", mem_write, 0);
        check("reset_mem_addr", mem_addr, 0);
        check("reset_mem_wdata", mem_wdata, 0);
        check("reset_out_port", out_port, 0);
        #9 clear = 1'b1;
        idle();
        #1;
        check("no_driver_bus", bus_dbg, 0);
        tick();

        // Instruction fetch T0..T2.
        idle(); pc_out = 1; mar_in = 1; inc_pc = 1; rz_in = 1; tick();
        idle(); rzlo_out = 1; pc_in = 1; rd = 1; mdr_in = 1; mdatain = 32'h0A000000; in_port = '0; tick();
        idle(); mdr_out = 1; ir_in = 1; tick(); idle();
        check("fetch_mar", mem_addr, 0);
        check("fetch_mdr", mem_wdata, 32'h0A000000);
        pc_out = 1; sample_bus(v); check("fetch_pc", v, 1);
        ir_out = 1; sample_bus(v); check("fetch_ir", v, 32'h0A000000);

        // MDR takes the bus when Read is low.
        idle(); in_port = 32'h00001234; inport_out = 1; mdr_in = 1; tick(); idle();
        check("mdr_from_bus", mem_wdata, 32'h00001234);

        // IN via Ra select.
        set_ir(32'h02000000);
        idle(); in_port = 32'hDEADBEEF; inport_out = 1; gra = 1; rin = 1; tick(); idle();
        get_reg(4, v); check("in_r4", v, 32'hDEADBEEF);
        gra = 1; rout = 1; sample_bus(v); check("in_r4_sel", v, 32'hDEADBEEF);

        // ADD R1 = R2 + R3.
        put_reg(2, 5); put_reg(3, 7);
        idle(); r_out[2] = 1; ry_in = 1; tick();
        idle(); r_out[3] = 1; ops_s = OP_ADD; rz_in = 1; tick();
        idle(); rzlo_out = 1; r_in[1] = 1; tick(); idle();
        get_reg(1, v); check("add_r1", v, 12);
        rzhi_out = 1; sample_bus(v); check("add_zhi", v, 0);

        run_alu(OP_MUL, 1'b0, 32'hFFFFFFFA, 32'h4, z);
        check("mul_neg6x4", z, 64'hFFFFFFFFFFFFFFE8);
        run_alu(OP_DIV, 1'b0, 32'd17, 32'd5, z);
        check("div_17_5", z, DIV_ON ? 64'h0000000200000003 : 64'h0);

        // BAout with R0 selected reads 0; Cout sign-extends IR[18:0].
        put_reg(0, 32'h55);
        set_ir(32'h0007FFFF);
        idle(); grb = 1; ba_out = 1; ry_in = 1; tick(); idle();
        ry_out = 1; sample_bus(v); check("baout_y", v, 0);
        grb = 1; rout = 1; sample_bus(v); check("rout_r0", v, 32'h55);
        idle(); c_out = 1; ops_s = OP_ADD; rz_in = 1; tick(); idle();
        rzlo_out = 1; sample_bus(v); check("cout_zlo", v, 32'hFFFFFFFF);
        set_ir(32'h0003FFFF);
        c_out = 1; sample_bus(v); check("cout_pos", v, 32'h0003FFFF);

        // Bus priority among multiple drivers.
        put_reg(1, 32'h11); put_reg(5, 32'h55);
        r_out[1] = 1; r_out[5] = 1; sample_bus(v); check("prio_r1_r5", v, 32'h11);
        r_out[5] = 1; ra_out = 1; sample_bus(v); check("prio_r5_ra", v, 32'h55);
        idle(); in_port = 32'hABCD0000; inport_out = 1; ry_in = 1; tick(); idle();
        ry_out = 1; inport_out = 1; in_port = 32'h1; sample_bus(v); check("prio_y_in", v, 32'hABCD0000);

        // Out port and memory write strobe.
        idle(); in_port = 32'hCAFEF00D; inport_out = 1; port_in = 1; tick(); idle();
        check("out_port", out_port, 32'hCAFEF00D);
        port_out = 1; sample_bus(v); check("port_out_bus", v, 32'hCAFEF00D);
        wr = 1; #1; check("mem_write", mem_write, 1); idle(); tick();

        foreach (vecs[i]) begin
            run_alu(vecs[i].op, vecs[i].inc, vecs[i].a, vecs[i].b, z);
            check($sformatf("vec%0d", i), z, vecs[i].exp);
        end

        for (int i = 0; i < 250; i++) begin
            logic [4:0]  op;
            bit          inc;
            logic [31:0] a, b;
            op  = 5'($urandom_range(0, 15));
            inc = ($urandom_range(0, 7) == 0);
            a   = $urandom;
            b   = $urandom;
            if (op == OP_DIV && $urandom_range(0, 1) == 1) b = 32'($signed(6'($urandom_range(0, 63))));
            if (op == OP_DIV && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'h1;
            run_alu(op, inc, a, b, z);
            check($sformatf("rand_alu op=%0d inc=%0d a=%h b=%h", op, inc, a, b), z, model(op, inc, a, b));
        end

        // Register file: direct and IR-selected writes and reads against an array model.
        for (int unsigned k = 0; k < 16; k++) begin
            rf[k] = $urandom;
            put_reg(k, rf[k]);
        end
        for (int i = 0; i < 40; i++) begin
            int unsigned k;
            k = $urandom_range(0, 15);
            case ($urandom_range(0, 3))
                0: begin
                    rf[k] = $urandom;
                    put_reg(k, rf[k]);
                end
                1: begin
                    set_ir(32'(k) << IR_RA_LSB);
                    rf[k] = $urandom;
                    idle(); in_port = rf[k]; inport_out = 1; gra = 1; rin = 1; tick(); idle();
                end
                2: begin
                    set_ir(32'(k) << IR_RC_LSB);
                    grc = 1; rout = 1; sample_bus(v);
                    check($sformatf("rf_sel_r%0d", k), v, rf[k]);
                end
                default: begin
                    get_reg(k, v);
                    check($sformatf("rf_r%0d", k), v, rf[k]);
                end
            endcase
        end

        // Asynchronous clear between clock edges.
        put_reg(1, 12);
        idle(); in_port = 32'h40; inport_out = 1; pc_in = 1; mar_in = 1; tick(); idle();
        run_alu(OP_ADD, 1'b0, 32'h3, 32'h4, z);
        check("pre_reset_zlo", z, 64'h7);
        #2 clear = 1'b0;
        #1;
        check("async_mar", mem_addr, 0);
        clear = 1'b1;
        r_out[1] = 1; #1; check("async_r1", bus_dbg, 0);
        idle(); pc_out = 1; #1; check("async_pc", bus_dbg, 0);
        idle(); rzlo_out = 1; #1; check("async_zlo", bus_dbg, 0);
        idle();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
